// File: rtl/pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_chain
// Brief    : N-stage pipeline register chain with valid bits, backward-propagating
//            stall, per-stage flush, youngest-match forwarding, occupancy and
//            saturating bubble counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_chain #(
   parameter int STAGES = 4,
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   localparam int c_IDX_W = $clog2(STAGES),
   localparam int c_OCC_W = $clog2(STAGES + 1)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_data,
   input  logic [REG_W-1:0]           in_dst,
   input  logic                       in_wr,
   output logic                       in_ready,
   input  logic [STAGES-1:0]          stall_req,
   input  logic [STAGES-1:0]          flush,
   output logic [STAGES-1:0]          st_valid,
   output logic [STAGES*DATA_W-1:0]   st_data,
   output logic [STAGES*REG_W-1:0]    st_dst,
   output logic [STAGES-1:0]          st_wr,
   output logic                       out_fire,
   input  logic [REG_W-1:0]           fwd_src,
   output logic                       fwd_hit,
   output logic [c_IDX_W-1:0]         fwd_stage,
   output logic [DATA_W-1:0]          fwd_data,
   output logic [c_OCC_W-1:0]         occ,
   output logic [15:0]                bubble_cnt
);

   logic [STAGES-1:0]  w_hold;
   logic [STAGES-1:0]  w_bub;
   logic [STAGES-1:0]  w_load;
   logic [STAGES-1:0]  w_nvalid;
   logic [STAGES-1:0]  w_src_valid;
   logic [STAGES-1:0]  w_src_wr;
   logic [DATA_W-1:0]  w_src_data [STAGES];
   logic [REG_W-1:0]   w_src_dst  [STAGES];
   logic [c_OCC_W-1:0] w_occ_next;

   logic [STAGES-1:0]  r_valid;
   logic [STAGES-1:0]  r_wr;
   logic [DATA_W-1:0]  r_data [STAGES];
   logic [REG_W-1:0]   r_dst  [STAGES];
   logic [c_OCC_W-1:0] r_occ;
   logic [15:0]        r_bub_cnt;

   generate
      for (genvar k = 0; k < STAGES; k++) begin : g_stage
         // A stage holds if it or any older stage requests a stall.
         assign w_hold[k] = |stall_req[STAGES-1:k];
         if (k == 0) begin : g_head
            assign w_src_valid[k] = in_valid;
            assign w_src_data[k]  = in_data;
            assign w_src_dst[k]   = in_dst;
            assign w_src_wr[k]    = in_wr;
            assign w_bub[k]       = 1'b0;
         end else begin : g_body
            assign w_src_valid[k] = r_valid[k-1];
            assign w_src_data[k]  = r_data[k-1];
            assign w_src_dst[k]   = r_dst[k-1];
            assign w_src_wr[k]    = r_wr[k-1];
            assign w_bub[k]       = ~flush[k] & ~w_hold[k] & w_hold[k-1];
         end
         assign w_load[k]   = ~flush[k] & ~w_hold[k] & ~w_bub[k];
         assign w_nvalid[k] = w_load[k] ? w_src_valid[k]
                                        : (~flush[k] & ~w_bub[k] & r_valid[k]);
         assign st_data[k*DATA_W +: DATA_W] = r_data[k];
         assign st_dst[k*REG_W +: REG_W]    = r_dst[k];
      end
   endgenerate

   always_comb begin
      w_occ_next = '0;
      for (int k = 0; k < STAGES; k++) begin
         w_occ_next = w_occ_next + c_OCC_W'(w_nvalid[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid   <= '0;
         r_wr      <= '0;
         r_occ     <= '0;
         r_bub_cnt <= '0;
         for (int k = 0; k < STAGES; k++) begin
            r_data[k] <= '0;
            r_dst[k]  <= '0;
         end
      end else begin
         r_valid <= w_nvalid;
         r_occ   <= w_occ_next;
         for (int k = 0; k < STAGES; k++) begin
            if (w_load[k]) begin
               r_data[k] <= w_src_data[k];
               r_dst[k]  <= w_src_dst[k];
               r_wr[k]   <= w_src_wr[k];
            end
         end
         if ((|w_bub) && (r_bub_cnt != 16'hFFFF)) begin
            r_bub_cnt <= r_bub_cnt + 16'd1;
         end
      end
   end

   // Scan oldest to youngest so the youngest matching stage wins.
   always_comb begin
      fwd_hit   = 1'b0;
      fwd_stage = '0;
      fwd_data  = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         if (r_valid[k] && r_wr[k] && (r_dst[k] == fwd_src) && (fwd_src != '0)) begin
            fwd_hit   = 1'b1;
            fwd_stage = c_IDX_W'(k);
            fwd_data  = r_data[k];
         end
      end
   end

   assign in_ready   = ~w_hold[0];
   assign out_fire   = r_valid[STAGES-1] & ~stall_req[STAGES-1];
   assign st_valid   = r_valid;
   assign st_wr      = r_wr;
   assign occ        = r_occ;
   assign bubble_cnt = r_bub_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_chain
// Brief    : Self-checking bench for pipe_stage_chain with retire scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_chain;

   localparam int STAGES = 4;
   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   logic                     clk;
   logic                     reset;
   logic                     in_valid;
   logic [DATA_W-1:0]        in_data;
   logic [REG_W-1:0]         in_dst;
   logic                     in_wr;
   logic                     in_ready;
   logic [STAGES-1:0]        stall_req;
   logic [STAGES-1:0]        flush;
   logic [STAGES-1:0]        st_valid;
   logic [STAGES*DATA_W-1:0] st_data;
   logic [STAGES*REG_W-1:0]  st_dst;
   logic [STAGES-1:0]        st_wr;
   logic                     out_fire;
   logic [REG_W-1:0]         fwd_src;
   logic                     fwd_hit;
   logic [1:0]               fwd_stage;
   logic [DATA_W-1:0]        fwd_data;
   logic [2:0]               occ;
   logic [15:0]              bubble_cnt;

   int                       n_chk;
   int                       n_fail;
   int                       max_occ;
   logic                     sb_on;
   logic [DATA_W-1:0]        sb_q[$];

   pipe_stage_chain #(.STAGES(STAGES), .DATA_W(DATA_W), .REG_W(REG_W)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_dst     (in_dst),
      .in_wr      (in_wr),
      .in_ready   (in_ready),
      .stall_req  (stall_req),
      .flush      (flush),
      .st_valid   (st_valid),
      .st_data    (st_data),
      .st_dst     (st_dst),
      .st_wr      (st_wr),
      .out_fire   (out_fire),
      .fwd_src    (fwd_src),
      .fwd_hit    (fwd_hit),
      .fwd_stage  (fwd_stage),
      .fwd_data   (fwd_data),
      .occ        (occ),
      .bubble_cnt (bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] sd(input int k);
      return st_data[k*DATA_W +: DATA_W];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [31:0] d, input logic [4:0] dst, input logic w);
      in_valid = 1'b1;
      in_data  = d;
      in_dst   = dst;
      in_wr    = w;
      tick();
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      stall_req = '0;
      flush     = '0;
      tick();
      reset = 1'b0;
   endtask

   // Scoreboard: push on acceptance, pop on retirement (sampled mid-cycle).
   always @(negedge clk) begin
      if (sb_on && !reset) begin
         if (in_valid && in_ready) sb_q.push_back(in_data);
         if (out_fire) begin
            if (sb_q.size() == 0) check_eq("sb_underflow", 32'd1, 32'd0);
            else check_eq("sb_retire", sd(STAGES-1), sb_q.pop_front());
         end
      end
   end

   initial begin
      n_chk = 0; n_fail = 0; max_occ = 0; sb_on = 1'b0;
      reset = 1'b1; in_valid = 1'b0; in_data = '0; in_dst = '0; in_wr = 1'b0;
      stall_req = '0; flush = '0; fwd_src = '0;
      tick();
      tick();
      check_eq("rst_valid", 32'(st_valid), 32'h0);
      check_eq("rst_occ", 32'(occ), 32'h0);
      check_eq("rst_bub", 32'(bubble_cnt), 32'h0);
      check_eq("rst_ready", 32'(in_ready), 32'h1);
      reset = 1'b0;

      // Three back-to-back items, no stall
      sb_on = 1'b1;
      feed(32'h11, 5'd1, 1'b1);
      if (32'(occ) > max_occ) max_occ = 32'(occ);
      feed(32'h22, 5'd2, 1'b1);
      if (32'(occ) > max_occ) max_occ = 32'(occ);
      feed(32'h33, 5'd3, 1'b1);
      if (32'(occ) > max_occ) max_occ = 32'(occ);
      in_valid = 1'b0;
      tick();
      check_eq("t1_s3_valid", 32'(st_valid[3]), 32'h1);
      check_eq("t1_s3_data", sd(3), 32'h11);
      check_eq("t1_fire", 32'(out_fire), 32'h1);
      for (int i = 0; i < 5; i++) begin
         if (32'(occ) > max_occ) max_occ = 32'(occ);
         tick();
      end
      check_eq("t1_occ_peak", 32'(max_occ), 32'd3);
      check_eq("t1_drained", 32'(occ), 32'd0);

      // Full pipe, stall stage 2 for two cycles
      feed(32'h41, 5'd1, 1'b1);
      feed(32'h42, 5'd2, 1'b1);
      feed(32'h43, 5'd3, 1'b1);
      feed(32'h44, 5'd4, 1'b1);
      in_valid = 1'b0;
      check_eq("t2_full", 32'(occ), 32'd4);
      stall_req = 4'b0100;
      #1;
      check_eq("t2_ready", 32'(in_ready), 32'h0);
      for (int c = 0; c < 2; c++) begin
         tick();
         check_eq("t2_valid", 32'(st_valid), 32'h7);
         check_eq("t2_s0", sd(0), 32'h44);
         check_eq("t2_s1", sd(1), 32'h43);
         check_eq("t2_s2", sd(2), 32'h42);
         check_eq("t2_occ", 32'(occ), 32'd3);
      end
      check_eq("t2_bub", 32'(bubble_cnt), 32'd2);
      stall_req = '0;
      for (int i = 0; i < 6; i++) tick();
      check_eq("t2_sb_empty", 32'(sb_q.size()), 32'd0);
      sb_on = 1'b0;

      // Flush stages 0,1 while stage 1 stalls; stage 2 empty beforehand
      do_reset();
      feed(32'h51, 5'd1, 1'b1);
      in_valid = 1'b0;
      tick();
      feed(32'h53, 5'd3, 1'b1);
      feed(32'h54, 5'd4, 1'b1);
      in_valid = 1'b0;
      check_eq("t3_pre_valid", 32'(st_valid), 32'hB);
      check_eq("t3_pre_fire", 32'(out_fire), 32'h1);
      flush = 4'b0011;
      stall_req = 4'b0010;
      tick();
      check_eq("t3_valid", 32'(st_valid), 32'h0);
      check_eq("t3_occ", 32'(occ), 32'd0);
      check_eq("t3_bub", 32'(bubble_cnt), 32'd1);
      check_eq("t3_keep_data", sd(0), 32'h54);
      flush = '0;
      stall_req = '0;

      // Forwarding lookups
      do_reset();
      feed(32'hBBBB, 5'd5, 1'b1);
      feed(32'h5050, 5'd0, 1'b1);
      feed(32'hAAAA, 5'd5, 1'b1);
      feed(32'h0099, 5'd9, 1'b0);
      in_valid = 1'b0;
      stall_req = 4'b1000;
      fwd_src = 5'd5;
      #1;
      check_eq("t4_hit", 32'(fwd_hit), 32'h1);
      check_eq("t4_stage", 32'(fwd_stage), 32'd1);
      check_eq("t4_data", fwd_data, 32'hAAAA);
      fwd_src = 5'd0;
      #1;
      check_eq("t4_r0_hit", 32'(fwd_hit), 32'h0);
      check_eq("t4_r0_data", fwd_data, 32'h0);
      fwd_src = 5'd9;
      #1;
      check_eq("t4_nowr_hit", 32'(fwd_hit), 32'h0);
      tick();
      check_eq("t4_held", 32'(st_valid), 32'hF);
      do_reset();
      feed(32'hBBBB, 5'd5, 1'b1);
      feed(32'h0077, 5'd7, 1'b1);
      feed(32'hAAAA, 5'd5, 1'b0);
      feed(32'h0099, 5'd9, 1'b0);
      in_valid = 1'b0;
      stall_req = 4'b1000;
      fwd_src = 5'd5;
      #1;
      check_eq("t4b_hit", 32'(fwd_hit), 32'h1);
      check_eq("t4b_stage", 32'(fwd_stage), 32'd3);
      check_eq("t4b_data", fwd_data, 32'hBBBB);

      // Reset mid-stall with flush active
      stall_req = 4'b0110;
      tick();
      check_eq("t5_pre_bub", 32'(bubble_cnt), 32'd1);
      flush = 4'b1010;
      reset = 1'b1;
      tick();
      check_eq("t5_valid", 32'(st_valid), 32'h0);
      check_eq("t5_occ", 32'(occ), 32'd0);
      check_eq("t5_bub", 32'(bubble_cnt), 32'd0);
      check_eq("t5_ready_stalled", 32'(in_ready), 32'h0);
      reset = 1'b0;
      stall_req = '0;
      flush = '0;
      #1;
      check_eq("t5_ready", 32'(in_ready), 32'h1);

      // Bubble counter saturation
      do_reset();
      stall_req = 4'b0001;
      for (int i = 0; i < 65534; i++) tick();
      check_eq("t6_count", 32'(bubble_cnt), 32'hFFFE);
      for (int i = 0; i < 70000 - 65534; i++) tick();
      check_eq("t6_sat", 32'(bubble_cnt), 32'hFFFF);
      stall_req = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
